sad_ctrl: RTL and testbench
===========================

Name: sad_ctrl

Overview:
- Sequencer and accumulator for one SAD (sum of absolute differences) block comparison.
- On a start handshake it generates read indices 0..N_PIX-1 for the two pixel memories (current block and reference block).
- It consumes the returned pixel pairs and accumulates |a-b|.
- It reports the result with a one-cycle done pulse; the result stays held until the next start.

Parameters:
- N_PIX, 256, pixels per block; number of indices issued; 1 <= N_PIX <= 2**ADDR_W
- PIX_W, 8, pixel width in bits
- ADDR_W, 9, index/address width
- SAD_W, 16, accumulator width; must satisfy (2**PIX_W-1)*N_PIX < 2**SAD_W

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a SAD run; sampled only in IDLE
- abort  input  1  synchronous cancel of a run in progress
- rd_en  output  1  memory read strobe, one per issued index
- addr  output  ADDR_W  read index presented to both pixel memories
- pix_a  input  PIX_W  current-block pixel, valid the cycle after rd_en
- pix_b  input  PIX_W  reference-block pixel, valid the cycle after rd_en
- busy  output  1  high in READ and DRAIN
- done  output  1  one-cycle pulse when sad is final
- sad  output  SAD_W  accumulated SAD, held after done

Behaviour:
- Reset (async, any state): state=IDLE, addr=0, rd_en=0, busy=0, done=0, sad=0, internal valid pipe=0.
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - start=1 -> READ; sad cleared to 0; addr=0.
  - start=0 -> stay.
- READ:
  - rd_en=1 every cycle; addr increments by 1 per cycle from 0.
  - In the cycle with addr=N_PIX-1 -> DRAIN next.
  - Exactly N_PIX strobes, no gaps.
- Memory latency is fixed at 1 cycle. A registered valid bit tracks rd_en. When it is set, sad <= sad + |pix_a - pix_b|.
  - The absolute difference is computed at PIX_W+1 bits and zero-extended to SAD_W.
  - No saturation; the parameter constraint guarantees no overflow.
- DRAIN: rd_en=0; accumulates the final pixel pair; -> DONE.
- DONE: done=1 for exactly one cycle; busy=0; -> IDLE. sad is stable from this cycle until the next accepted start.
- Timing: start sampled at edge 0. rd_en high for edges 1..N_PIX. done is high in the cycle after edge N_PIX+2. Run latency is N_PIX+2 cycles.
- start while busy or in DONE: ignored, no queuing.
- abort in READ or DRAIN: -> IDLE next edge; rd_en=0, addr=0, sad=0, valid pipe cleared; no done pulse.
- abort in IDLE or DONE: no effect. abort has priority over start in the same cycle.
- addr after a run: returns to 0 in IDLE. addr never exceeds N_PIX-1 and never wraps inside a run.
- Reset mid-run: immediate return to the reset values; a later start runs a full fresh block.

Decomposition:
- Shared package sad_pkg holds:
  - the state enum (IDLE, READ, DRAIN, DONE)
  - constants PIX_W, N_PIX, ADDR_W, SAD_W, used by the memory wrappers and the top level
- One natural sub-module: sad_absacc. It holds the valid pipe register, the |a-b| logic and the SAD_W accumulator, with clear and accumulate-enable inputs.
- The FSM and index generation stay in sad_ctrl.

Test Plan:
- Identical blocks: pix_a=pix_b=0x5A for all 256 indices -> done once, sad=0; rd_en high exactly 256 cycles; addr 0..255.
- Maximum difference: pix_a=255, pix_b=0 everywhere -> sad=65280 (0xFF00); no overflow; done 258 cycles after start.
- Sign check: pix_a=10, pix_b=20 everywhere -> sad=2560. Ramp case pix_a=addr[7:0], pix_b=0 -> sad=32640.
- start pulsed during READ, and again in the DONE cycle -> ignored; exactly one done; sad unchanged until the next start from IDLE.
- abort at addr=100 -> IDLE next cycle, rd_en=0, sad=0, no done. A following start gives the correct full result.
- Async rst at addr=50 mid-cycle -> outputs zero immediately without waiting for a clock edge. Back-to-back runs with start re-asserted in the cycle after done -> second run accepted and its result correct.

Source files
------------

// File: rtl/sad_pkg.sv
// Shared constants and FSM state type for the SAD block-compare slice.
package sad_pkg;

  localparam int unsigned N_PIX  = 256;
  localparam int unsigned PIX_W  = 8;
  localparam int unsigned ADDR_W = 9;
  localparam int unsigned SAD_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_t;

endpackage

// File: rtl/sad_absacc.sv
// Valid pipe plus |a-b| accumulator; one-cycle memory latency is absorbed by the valid register.
module sad_absacc #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned SAD_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [PIX_W-1:0] pix_a,
  input  logic [PIX_W-1:0] pix_b,
  output logic [SAD_W-1:0] sad
);

  logic             vld;
  logic [PIX_W:0]   diff;

  always_comb begin
    if (pix_a >= pix_b) diff = {1'b0, pix_a} - {1'b0, pix_b};
    else                diff = {1'b0, pix_b} - {1'b0, pix_a};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= 1'b0;
      sad <= '0;
    end else if (clr) begin
      vld <= 1'b0;
      sad <= '0;
    end else begin
      vld <= en;
      if (vld) sad <= sad + SAD_W'(diff);
    end
  end

endmodule

// File: rtl/sad_ctrl.sv
// SAD run sequencer: issues N_PIX read indices, drains the last pixel pair, pulses done.
module sad_ctrl #(
  parameter int unsigned N_PIX  = sad_pkg::N_PIX,
  parameter int unsigned PIX_W  = sad_pkg::PIX_W,
  parameter int unsigned ADDR_W = sad_pkg::ADDR_W,
  parameter int unsigned SAD_W  = sad_pkg::SAD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  input  logic [PIX_W-1:0]  pix_a,
  input  logic [PIX_W-1:0]  pix_b,
  output logic              busy,
  output logic              done,
  output logic [SAD_W-1:0]  sad
);

  import sad_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_PIX - 1);

  state_t state;
  logic   clr;

  // Accumulator is cleared both on an accepted start and on an abort of a live run.
  always_comb begin
    clr = 1'b0;
    if (state == IDLE && start) clr = 1'b1;
    if (abort && (state == READ || state == DRAIN)) clr = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr  <= '0;
      rd_en <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state <= READ;
            addr  <= '0;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        READ: begin
          if (abort) begin
            state <= IDLE;
            addr  <= '0;
            rd_en <= 1'b0;
            busy  <= 1'b0;
          end else if (addr == LAST) begin
            state <= DRAIN;
            addr  <= '0;
            rd_en <= 1'b0;
          end else begin
            addr <= addr + 1'b1;
          end
        end
        DRAIN: begin
          busy <= 1'b0;
          if (abort) begin
            state <= IDLE;
          end else begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  sad_absacc #(
    .PIX_W(PIX_W),
    .SAD_W(SAD_W)
  ) u_absacc (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .en   (rd_en),
    .pix_a(pix_a),
    .pix_b(pix_b),
    .sad  (sad)
  );

endmodule

// File: tb/tb_sad_ctrl.sv
// Self-checking bench for sad_ctrl: memory model with 1-cycle latency and an arithmetic SAD reference.
module tb_sad_ctrl;

  import sad_pkg::*;

  logic              clk;
  logic              rst;
  logic              start;
  logic              abort;
  logic              rd_en;
  logic [ADDR_W-1:0] addr;
  logic [PIX_W-1:0]  pix_a;
  logic [PIX_W-1:0]  pix_b;
  logic              busy;
  logic              done;
  logic [SAD_W-1:0]  sad;

  int checks = 0;
  int errors = 0;

  int mem_a [N_PIX];
  int mem_b [N_PIX];

  sad_ctrl #(
    .N_PIX (N_PIX),
    .PIX_W (PIX_W),
    .ADDR_W(ADDR_W),
    .SAD_W (SAD_W)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .abort(abort),
    .rd_en(rd_en),
    .addr (addr),
    .pix_a(pix_a),
    .pix_b(pix_b),
    .busy (busy),
    .done (done),
    .sad  (sad)
  );

  always #5 clk = ~clk;

  // Two synchronous-read pixel memories sharing one index.
  always @(posedge clk) begin
    if (rd_en === 1'b1) begin
      pix_a <= PIX_W'(mem_a[int'(addr)]);
      pix_b <= PIX_W'(mem_b[int'(addr)]);
    end
  end

  function automatic logic [SAD_W-1:0] ref_sad();
    int sum;
    sum = 0;
    for (int i = 0; i < N_PIX; i++) begin
      if (mem_a[i] > mem_b[i]) sum += mem_a[i] - mem_b[i];
      else                     sum += mem_b[i] - mem_a[i];
    end
    return sum[SAD_W-1:0];
  endfunction

  // mode: 0 identical, 1 max diff, 2 sign, 3 ramp, other random
  task automatic fill(input int mode);
    for (int i = 0; i < N_PIX; i++) begin
      case (mode)
        0:       begin mem_a[i] = 'h5A; mem_b[i] = 'h5A; end
        1:       begin mem_a[i] = 255;  mem_b[i] = 0;    end
        2:       begin mem_a[i] = 10;   mem_b[i] = 20;   end
        3:       begin mem_a[i] = i % 256; mem_b[i] = 0; end
        default: begin
          mem_a[i] = int'($urandom_range(0, 255));
          mem_b[i] = int'($urandom_range(0, 255));
        end
      endcase
    end
  endtask

  // Observation only: starts a run at the current negedge and records what the DUT does.
  task automatic do_run(input int win, input int inj1, input int inj2,
                        output int strobes, output int busy_cyc, output int dones,
                        output int lat, output bit addr_ok,
                        output logic [SAD_W-1:0] sad_done, output logic [SAD_W-1:0] sad_end);
    int nexp;
    strobes = 0; busy_cyc = 0; dones = 0; lat = -1; addr_ok = 1; nexp = 0;
    sad_done = '0;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= win; k++) begin
      @(negedge clk);
      start = (k == inj1) || (k == inj2);
      if (rd_en === 1'b1) begin
        if (int'(addr) != nexp) addr_ok = 0;
        strobes++;
        nexp++;
      end
      if (busy === 1'b1) busy_cyc++;
      if (done === 1'b1) begin
        dones++;
        if (lat < 0) begin
          lat = k;
          sad_done = sad;
        end
      end
    end
    start = 1'b0;
    sad_end = sad;
  endtask

  task automatic test_reset();
    checks++;
    if ({rd_en, busy, done} !== 3'b000) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000", {rd_en, busy, done});
    end
    checks++;
    if (addr !== '0) begin
      errors++; $display("FAIL reset_addr: got %0d expected 0", addr);
    end
    checks++;
    if (sad !== '0) begin
      errors++; $display("FAIL reset_sad: got %0d expected 0", sad);
    end
  endtask

  task automatic test_pattern(input string name, input int mode);
    int st, bc, dn, lat;
    bit aok;
    logic [SAD_W-1:0] sd, se, exp;
    fill(mode);
    exp = ref_sad();
    do_run(N_PIX + 6, -1, -1, st, bc, dn, lat, aok, sd, se);
    checks++;
    if (sd !== exp) begin
      errors++; $display("FAIL %s_sad: got %0d expected %0d", name, sd, exp);
    end
    checks++;
    if (dn != 1) begin
      errors++; $display("FAIL %s_dones: got %0d expected 1", name, dn);
    end
    checks++;
    if (st != N_PIX) begin
      errors++; $display("FAIL %s_strobes: got %0d expected %0d", name, st, N_PIX);
    end
    checks++;
    if (!aok) begin
      errors++; $display("FAIL %s_addr_seq: got out-of-order expected 0..%0d", name, N_PIX - 1);
    end
    checks++;
    if (lat != N_PIX + 2) begin
      errors++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, N_PIX + 2);
    end
    checks++;
    if (bc != N_PIX + 1) begin
      errors++; $display("FAIL %s_busy_cycles: got %0d expected %0d", name, bc, N_PIX + 1);
    end
    checks++;
    if (se !== exp || addr !== '0) begin
      errors++; $display("FAIL %s_held: got sad=%0d addr=%0d expected sad=%0d addr=0", name, se, addr, exp);
    end
  endtask

  task automatic test_start_ignored();
    int st, bc, dn, lat;
    bit aok;
    logic [SAD_W-1:0] sd, se, exp;
    fill(9);
    exp = ref_sad();
    do_run(N_PIX + 8, 50, N_PIX + 2, st, bc, dn, lat, aok, sd, se);
    checks++;
    if (dn != 1 || st != N_PIX) begin
      errors++; $display("FAIL ignore_start_count: got dones=%0d strobes=%0d expected 1 %0d", dn, st, N_PIX);
    end
    checks++;
    if (sd !== exp || se !== exp) begin
      errors++; $display("FAIL ignore_start_sad: got %0d/%0d expected %0d", sd, se, exp);
    end
    checks++;
    if (rd_en !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL ignore_start_idle: got rd_en=%b busy=%b expected 0 0", rd_en, busy);
    end
  endtask

  task automatic test_abort();
    int st, bc, dn, lat, nd, nr;
    bit aok, found;
    logic [SAD_W-1:0] sd, se, exp;
    fill(9);
    mem_a[0] = 200; mem_b[0] = 0;
    exp = ref_sad();
    found = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < N_PIX + 4; k++) begin
      if (rd_en === 1'b1 && int'(addr) == 100) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL abort_reach_addr: got timeout expected addr=100");
    end
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    checks++;
    if ({rd_en, busy, done} !== 3'b000 || addr !== '0 || sad !== '0) begin
      errors++; $display("FAIL abort_state: got rd_en=%b busy=%b done=%b addr=%0d sad=%0d expected all 0",
                         rd_en, busy, done, addr, sad);
    end
    nd = 0; nr = 0;
    for (int k = 0; k < N_PIX + 5; k++) begin
      @(negedge clk);
      if (done === 1'b1) nd++;
      if (rd_en === 1'b1) nr++;
    end
    checks++;
    if (nd != 0 || nr != 0) begin
      errors++; $display("FAIL abort_quiet: got dones=%0d strobes=%0d expected 0 0", nd, nr);
    end
    do_run(N_PIX + 6, -1, -1, st, bc, dn, lat, aok, sd, se);
    checks++;
    if (sd !== exp || dn != 1 || st != N_PIX) begin
      errors++; $display("FAIL abort_rerun: got sad=%0d dones=%0d strobes=%0d expected %0d 1 %0d",
                         sd, dn, st, exp, N_PIX);
    end
  endtask

  task automatic test_async_reset();
    int st, bc, dn, lat;
    bit aok, found;
    logic [SAD_W-1:0] sd, se, exp;
    fill(9);
    mem_a[3] = 255; mem_b[3] = 0;
    found = 0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < N_PIX + 4; k++) begin
      if (rd_en === 1'b1 && int'(addr) == 50) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found || sad === '0) begin
      errors++; $display("FAIL rst_reach_addr: got found=%0d sad=%0d expected 1 nonzero", found, sad);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({rd_en, busy, done} !== 3'b000 || addr !== '0 || sad !== '0) begin
      errors++; $display("FAIL rst_async: got rd_en=%b busy=%b done=%b addr=%0d sad=%0d expected all 0",
                         rd_en, busy, done, addr, sad);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    fill(9);
    exp = ref_sad();
    do_run(N_PIX + 6, -1, -1, st, bc, dn, lat, aok, sd, se);
    checks++;
    if (sd !== exp || dn != 1 || st != N_PIX || !aok) begin
      errors++; $display("FAIL rst_rerun: got sad=%0d dones=%0d strobes=%0d expected %0d 1 %0d",
                         sd, dn, st, exp, N_PIX);
    end
  endtask

  task automatic test_back_to_back();
    int st, bc, dn, lat;
    bit aok;
    logic [SAD_W-1:0] sd, se, exp1, exp2;
    fill(9);
    exp1 = ref_sad();
    do_run(N_PIX + 3, -1, -1, st, bc, dn, lat, aok, sd, se);
    checks++;
    if (sd !== exp1 || lat != N_PIX + 2) begin
      errors++; $display("FAIL b2b_first: got sad=%0d lat=%0d expected %0d %0d", sd, lat, exp1, N_PIX + 2);
    end
    fill(9);
    exp2 = ref_sad();
    do_run(N_PIX + 6, -1, -1, st, bc, dn, lat, aok, sd, se);
    checks++;
    if (sd !== exp2 || dn != 1 || st != N_PIX || lat != N_PIX + 2) begin
      errors++; $display("FAIL b2b_second: got sad=%0d dones=%0d strobes=%0d lat=%0d expected %0d 1 %0d %0d",
                         sd, dn, st, lat, exp2, N_PIX, N_PIX + 2);
    end
  endtask

  initial begin
    clk = 1'b0;
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    #12;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_pattern("identical", 0);
    test_pattern("maxdiff", 1);
    test_pattern("sign", 2);
    test_pattern("ramp", 3);
    for (int r = 0; r < 3; r++) test_pattern("random", 9);
    test_start_ignored();
    test_abort();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
